// File: rtl/clock_period_meter_if.sv
// Measurement bus of the clock period meter: the signal under test going in,
// the half-period result and its status flags coming out.
interface clock_period_meter_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 sig_in;
    logic [CNT_WIDTH-1:0] half_period;
    logic                 meas_valid;
    logic                 locked;
    logic                 timeout;

    // Drives the signal under test and consumes the results.
    modport master (
        output sig_in,
        input  half_period,
        input  meas_valid,
        input  locked,
        input  timeout
    );

    // The meter itself.
    modport slave (
        input  sig_in,
        output half_period,
        output meas_valid,
        output locked,
        output timeout
    );
endinterface

// File: rtl/clock_period_meter.sv
// Measures each half-period of a slow square wave in clk_in cycles, reported
// as (cycles between successive edges - 1), so a divider with terminal count N
// reads back as N. Also flags loss of signal (timeout) and a stable frequency
// (locked: LOCK_COUNT consecutive measurements within TOL of their
// predecessor).
module clock_period_meter #(
    parameter int CNT_WIDTH      = 32,
    parameter int TIMEOUT_CNTMAX = 49999999,
    parameter int TOL            = 1,
    parameter int LOCK_COUNT     = 3
) (
    input  logic                   clk_in,
    input  logic                   rst_n,
    clock_period_meter_if.slave    mon
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] MEASURE = 2'd1;
    localparam logic [1:0] LOST    = 2'd2;

    localparam int MC_W = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(TIMEOUT_CNTMAX);
    localparam logic [CNT_WIDTH-1:0] TOL_C    = CNT_WIDTH'(TOL);
    localparam logic [MC_W-1:0]      LOCK_MAX = MC_W'(LOCK_COUNT);

    logic                 s1, s2, s3;
    logic                 sig_edge;
    logic [CNT_WIDTH-1:0] cnt;
    logic [1:0]           state;
    logic                 have_prev;
    logic [CNT_WIDTH-1:0] prev_meas;
    logic [MC_W-1:0]      match_cnt;
    logic [MC_W-1:0]      match_next;
    logic [CNT_WIDTH-1:0] meas_diff;
    logic                 within_tol;

    logic [CNT_WIDTH-1:0] half_period_q;
    logic                 meas_valid_q;
    logic                 locked_q;
    logic                 timeout_q;

    // Two-flop synchronizer for the asynchronous input, plus one delay flop
    // for edge detection.
    // NOTE: every sequential assignment is non-blocking so each flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the
    // chain into a single stage.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= mon.sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Both polarities count as an edge; no glitch filtering.
    assign sig_edge = s2 ^ s3;

    // Cycles since the last edge, saturating at the timeout value.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (sig_edge) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_WIDTH'(1);
        end
    end

    // Distance to the previous measurement, subtracted in the order that
    // cannot underflow, and the resulting saturating match count.
    // NOTE: every signal gets a value on every path through this block, so
    // no latch is inferred.
    always_comb begin
        meas_diff  = '0;
        match_next = '0;
        if (cnt >= prev_meas) begin
            meas_diff = cnt - prev_meas;
        end else begin
            meas_diff = prev_meas - cnt;
        end
        within_tol = (meas_diff <= TOL_C);
        if (within_tol) begin
            match_next = (match_cnt == LOCK_MAX) ? match_cnt : match_cnt + MC_W'(1);
        end
    end

    // Control FSM: reports measurements, tracks lock and detects signal loss.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state         <= IDLE;
            have_prev     <= 1'b0;
            prev_meas     <= '0;
            match_cnt     <= '0;
            half_period_q <= '0;
            meas_valid_q  <= 1'b0;
            locked_q      <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            meas_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (sig_edge) begin
                        state     <= MEASURE;
                        have_prev <= 1'b0;
                    end
                end
                MEASURE: begin
                    // An edge wins over a simultaneous saturation of the counter.
                    if (sig_edge) begin
                        half_period_q <= cnt;
                        meas_valid_q  <= 1'b1;
                        prev_meas     <= cnt;
                        if (!have_prev) begin
                            have_prev <= 1'b1;
                        end else begin
                            match_cnt <= match_next;
                            locked_q  <= (match_next == LOCK_MAX);
                        end
                    end else if (cnt == CNT_MAX) begin
                        state     <= LOST;
                        timeout_q <= 1'b1;
                        locked_q  <= 1'b0;
                        match_cnt <= '0;
                    end
                end
                LOST: begin
                    // Re-arm without reporting; the next measurement has no
                    // predecessor.
                    if (sig_edge) begin
                        state     <= MEASURE;
                        timeout_q <= 1'b0;
                        have_prev <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign mon.half_period = half_period_q;
    assign mon.meas_valid  = meas_valid_q;
    assign mon.locked      = locked_q;
    assign mon.timeout     = timeout_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter with a scoreboard: every toggle of
// sig_in that should produce a report pushes the expected half-period and
// lock state; a monitor pops and compares on each meas_valid pulse.
module tb_clock_period_meter;

    localparam int CW = 32;

    typedef struct packed {
        logic [CW-1:0] hp;
        logic          lk;
    } exp_t;

    logic clk_in;
    logic rst_n;

    clock_period_meter_if #(.CNT_WIDTH(CW)) bus ();

    clock_period_meter #(
        .CNT_WIDTH      (CW),
        .TIMEOUT_CNTMAX (99),
        .TOL            (1),
        .LOCK_COUNT     (3)
    ) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .mon    (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    // Reference model state.
    bit   m_active = 0;
    bit   m_first  = 0;
    int   m_prev   = 0;
    int   m_match  = 0;
    bit   m_locked = 0;
    int   m_last_hp = 0;
    int   since_toggle = 0;

    logic prev_mv = 1'b0;
    logic timeout_seen = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Model of one detected edge, given the cycle count since the last toggle.
    task automatic model_edge(input int d);
        int   m;
        int   diff;
        exp_t e;
        if (!m_active) begin
            m_active = 1;
            m_first  = 1;
            return;
        end
        m = d - 1;
        if (m_first) begin
            m_first = 0;
        end else begin
            diff = (m > m_prev) ? m - m_prev : m_prev - m;
            if (diff <= 1) begin
                if (m_match < 3) m_match++;
                m_locked = (m_match == 3);
            end else begin
                m_match  = 0;
                m_locked = 0;
            end
        end
        m_prev    = m;
        m_last_hp = m;
        e.hp = CW'(m);
        e.lk = m_locked;
        exp_q.push_back(e);
    endtask

    task automatic model_lost();
        m_active = 0;
        m_match  = 0;
        m_locked = 0;
    endtask

    task automatic model_reset();
        m_active  = 0;
        m_first   = 0;
        m_prev    = 0;
        m_match   = 0;
        m_locked  = 0;
        m_last_hp = 0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(negedge clk_in);
            since_toggle++;
        end
    endtask

    task automatic step(input int d);
        wait_cyc(d);
        bus.sig_in = ~bus.sig_in;
        model_edge(since_toggle);
        since_toggle = 0;
    endtask

    // Monitor: pulse width, scoreboard comparison and timeout observation.
    always @(negedge clk_in) begin
        exp_t e;
        if (rst_n && bus.meas_valid) begin
            check("mv_width", prev_mv, 1'b0);
            check("mv_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("half_period", bus.half_period, e.hp);
                check("locked_at_report", bus.locked, e.lk);
            end
        end
        prev_mv = bus.meas_valid;
        if (bus.timeout) timeout_seen = 1'b1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        bus.sig_in = 1'b0;

        // Reset held while sig_in toggles: every output stays 0.
        for (int i = 0; i < 8; i++) begin
            repeat (3) @(negedge clk_in);
            bus.sig_in = ~bus.sig_in;
            check("reset_outputs",
                  {bus.half_period, bus.meas_valid, bus.locked, bus.timeout}, '0);
        end
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;
        wait_cyc(5);

        // Steady period of 10 cycles: reports 9, lock from the 4th report.
        step(10);
        for (int i = 0; i < 5; i++) step(10);
        wait_cyc(4);
        check("steady_locked", bus.locked, 1'b1);
        check("steady_hp", bus.half_period, CW'(9));

        // Frequency step: a transition half-period of 12, then 14.
        step(12);
        for (int i = 0; i < 5; i++) step(14);
        wait_cyc(4);
        check("step_relocked", bus.locked, 1'b1);
        check("step_hp", bus.half_period, CW'(13));

        // Jitter within TOL: 10/11 alternating.
        for (int i = 0; i < 4; i++) begin
            step(10);
            step(11);
        end
        wait_cyc(4);
        check("jitter_tol_locked", bus.locked, 1'b1);

        // Jitter beyond TOL: 10/12 alternating.
        for (int i = 0; i < 4; i++) begin
            step(10);
            step(12);
        end
        wait_cyc(4);
        check("jitter_wide_unlocked", bus.locked, 1'b0);

        // Relock at 10, then lose the signal.
        for (int i = 0; i < 4; i++) step(10);
        wait_cyc(102);
        check("timeout_not_yet", bus.timeout, 1'b0);
        wait_cyc(1);
        check("timeout_set", bus.timeout, 1'b1);
        check("timeout_unlocked", bus.locked, 1'b0);
        check("timeout_hp_held", bus.half_period, CW'(m_last_hp));
        model_lost();
        wait_cyc(20);
        check("timeout_still_set", bus.timeout, 1'b1);

        // Resume: first edge clears timeout without a report.
        step(5);
        wait_cyc(3);
        check("timeout_cleared", bus.timeout, 1'b0);
        timeout_seen = 1'b0;

        // Boundary: edges exactly TIMEOUT_CNTMAX+1 apart.
        step(7);
        step(100);
        step(100);
        wait_cyc(5);
        check("boundary_hp", bus.half_period, CW'(99));
        check("boundary_no_timeout", timeout_seen, 1'b0);

        // Reset in the middle of a half-period with sig_in low.
        if (bus.sig_in) step(10);
        wait_cyc(6);
        step(10);
        step(10);
        wait_cyc(4);
        rst_n = 1'b0;
        @(negedge clk_in);
        check("midreset_outputs",
              {bus.half_period, bus.meas_valid, bus.locked, bus.timeout}, '0);
        check("midreset_state_idle", dut.state, 2'd0);
        model_reset();
        since_toggle = 0;
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;
        step(3);
        step(10);
        wait_cyc(5);
        check("post_reset_hp", bus.half_period, CW'(9));
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_period_meter.md
Name: clock_period_meter

Overview:
- Measures the half-period of a slow square wave, such as a divided clock or an external tick, in cycles of the system clock.
- Reports each half-period as (cycles between successive edges − 1). This matches the team's divider parameter convention: a divider with terminal count N toggles every N+1 cycles and measures as N.
- Flags loss of signal (timeout) and frequency stability (lock).
- Sits beside the clock dividers as a self-check and frequency-monitor block.

Parameters:
- CNT_WIDTH, 32, width of the internal counter and of half_period.
- TIMEOUT_CNTMAX, 49999999, counter value at which a missing edge is declared lost.
- TOL, 1, maximum absolute difference between consecutive measurements that still counts as a match.
- LOCK_COUNT, 3, consecutive matches required to assert locked (≥1).

Ports:
- clk_in  input  1  system clock; all logic is on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- sig_in  input  1  signal under measurement; asynchronous to clk_in.
- half_period  output  CNT_WIDTH  last measured half-period minus one.
- meas_valid  output  1  one-cycle pulse when half_period updates.
- locked  output  1  high while measurements are stable within TOL.
- timeout  output  1  high while no edge has arrived within the timeout window.

Behaviour:
- Reset: rst_n is sampled low on a clk_in rising edge. Everything clears in that cycle:
  - half_period=0, meas_valid=0, locked=0, timeout=0.
  - Counter=0, match count=0, stored previous measurement=0.
  - Synchronizer flops=0, state=IDLE.
  - Reset overrides everything, including mid-measurement.
- Input path:
  - 2-flop synchronizer (s1, s2), then a delay flop s3.
  - edge = s2 XOR s3; both polarities count. A toggle on sig_in produces edge 2 cycles later.
  - No glitch filtering: a 1-cycle pulse gives two edges.
- Counter:
  - Cleared to 0 on an edge cycle; otherwise increments.
  - Saturates at TIMEOUT_CNTMAX and never wraps.
- States:
  - IDLE: waiting for the first edge. On edge: go to MEASURE, counter=0, no report.
  - MEASURE: on edge:
    - half_period<=counter; meas_valid<=1 for the next cycle only.
    - Run the lock update.
    - Stay in MEASURE.
  - MEASURE, timeout: counter==TIMEOUT_CNTMAX with no edge in that cycle:
    - Go to LOST; timeout<=1, locked<=0, match count=0.
    - half_period holds its value.
  - LOST: on edge: go to MEASURE, timeout<=0, counter=0, no report. The first measurement afterwards has no predecessor.
- Simultaneous edge and counter==TIMEOUT_CNTMAX in MEASURE: the edge wins. A measurement of TIMEOUT_CNTMAX is reported and there is no timeout.
- Lock update, on each reported measurement m:
  - First measurement after IDLE or LOST: store prev=m; match count stays 0; locked stays 0.
  - Otherwise, if |m − prev| ≤ TOL (unsigned compare, computed without overflow): match count increments, saturating at LOCK_COUNT.
  - Otherwise: match count=0 and locked=0.
  - Always set prev=m.
  - locked rises when match count reaches LOCK_COUNT. It is registered together with meas_valid, so it changes in the same cycle meas_valid is high.
- Latency: a sig_in toggle captured at clock k produces edge at k+2 and registered outputs visible at k+3.
- All outputs are registered; no combinational path from sig_in to any output.

Test Plan:
- Bench parameters for all scenarios: TIMEOUT_CNTMAX=99, TOL=1, LOCK_COUNT=3.
- Reset: hold rst_n low while sig_in toggles -> all outputs 0 throughout. After release, no meas_valid until two edges have been seen.
- Steady period: sig_in toggles every 10 clk_in cycles -> first meas_valid comes on the 2nd edge with half_period=9, exactly one cycle wide. locked=1 from the 4th meas_valid onward.
- Frequency step: after lock, switch to toggling every 14 cycles -> the transition measurement reports a value other than 9 or 13, and locked drops on that meas_valid. Measurements then read 13, and locked re-asserts once 3 consecutive reports of 13 match.
- Jitter within TOL: alternate half-periods of 10 and 11 cycles -> reports alternate 9 and 10, locked asserts and stays 1. Alternate 10 and 12 -> locked never asserts.
- Signal loss: after lock, hold sig_in constant -> timeout=1 and locked=0 once the counter reaches 99; half_period unchanged. Resume toggling -> timeout clears on the first edge with no report; the next edge reports.
- Boundary and reset: edges exactly 100 cycles apart -> half_period=99, timeout stays 0. Assert rst_n low mid-half-period -> outputs 0 next cycle, state IDLE.
